// File: rtl/mem_op_pkg.sv
// Shared encodings for the data-side memory request path:
// op_type codes, bus size codes and the issuer FSM states.
package mem_op_pkg;

    localparam logic [2:0] OP_B  = 3'd0;
    localparam logic [2:0] OP_BU = 3'd1;
    localparam logic [2:0] OP_H  = 3'd2;
    localparam logic [2:0] OP_HU = 3'd3;
    localparam logic [2:0] OP_W  = 3'd4;
    localparam logic [2:0] OP_WL = 3'd5;
    localparam logic [2:0] OP_WR = 3'd6;
    localparam logic [2:0] OP_X  = 3'd7;

    localparam logic [1:0] SZ_BYTE = 2'd0;
    localparam logic [1:0] SZ_HALF = 2'd1;
    localparam logic [1:0] SZ_WORD = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WAIT,
        ST_RESP,
        ST_DROP
    } state_t;

    // Illegal code 7 behaves like a plain word access.
    function automatic logic is_misaligned(
        input logic [2:0] t,
        input logic [1:0] o
    );
        logic h;
        logic w;
        h = (t == OP_H) | (t == OP_HU);
        w = (t == OP_W) | (t == OP_X);
        return (h & o[0]) | (w & (o != 2'b00));
    endfunction

endpackage

// File: rtl/data_sram_req_if.sv
// SRAM-like data bus between the request issuer (master)
// and the memory side (slave).
interface data_sram_req_if;

    logic        data_req;
    logic        data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr;
    logic [3:0]  data_wstrb;
    logic [31:0] data_wdata;
    logic        data_addr_ok;
    logic        data_data_ok;
    logic [31:0] data_rdata;

    modport master (
        output data_req,
        output data_wr,
        output data_size,
        output data_addr,
        output data_wstrb,
        output data_wdata,
        input  data_addr_ok,
        input  data_data_ok,
        input  data_rdata
    );

    modport slave (
        input  data_req,
        input  data_wr,
        input  data_size,
        input  data_addr,
        input  data_wstrb,
        input  data_wdata,
        output data_addr_ok,
        output data_data_ok,
        output data_rdata
    );

endinterface

// File: rtl/store_align.sv
// Combinational store lane alignment: bus size, byte strobes
// and lane-positioned write data for one memory op.
module store_align
    import mem_op_pkg::*;
(
    input  logic [2:0]  op_type,
    input  logic        op_store,
    input  logic [1:0]  off,
    input  logic [31:0] rt,
    output logic [1:0]  size,
    output logic [3:0]  strobe,
    output logic [31:0] wdata
);

    logic is_b;
    logic is_h;
    logic is_wl;
    logic is_wr;
    logic is_w;
    logic [3:0] st;

    assign is_b  = (op_type == OP_B) | (op_type == OP_BU);
    assign is_h  = (op_type == OP_H) | (op_type == OP_HU);
    assign is_wl = (op_type == OP_WL);
    assign is_wr = (op_type == OP_WR);
    assign is_w  = ~(is_b | is_h | is_wl | is_wr);

    always_comb begin
        size  = SZ_WORD;
        st    = 4'b1111;
        wdata = rt;
        unique case (1'b1)
            is_b: begin
                size  = SZ_BYTE;
                st    = 4'b0001 << off;
                wdata = {4{rt[7:0]}};
            end
            is_h: begin
                size  = SZ_HALF;
                st    = off[1] ? 4'b1100 : 4'b0011;
                wdata = {2{rt[15:0]}};
            end
            // swl fills from the addressed byte down to lane 0
            is_wl: begin
                st    = 4'b1111 >> ~off;
                wdata = rt >> {~off, 3'b000};
            end
            is_wr: begin
                st    = 4'b1111 << off;
                wdata = rt << {off, 3'b000};
            end
            is_w: begin
                st    = 4'b1111;
                wdata = rt;
            end
        endcase
        strobe = op_store ? st : 4'b0000;
    end

endmodule

// File: rtl/data_sram_req.sv
// Data-side request issuer between EXE and MEM; one op in flight.
// Define DATA_REQ_ADEL_CHECK_EN to trap misaligned h/w ops.
module data_sram_req
    import mem_op_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        cancel,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic        op_store,
    input  logic [2:0]  op_type,
    input  logic [31:0] op_addr,
    input  logic [31:0] op_wdata,
    data_sram_req_if.master bus,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_store,
    output logic        resp_err
);

    state_t state;
    state_t nxt;

    logic        accept;
    logic        mis;
    logic        cxl_q;
    logic        wl_wr;
    logic [1:0]  a_size;
    logic [3:0]  a_strb;
    logic [31:0] a_wdata;

    logic        r_store;
    logic [1:0]  r_size;
    logic [31:0] r_addr;
    logic [3:0]  r_strb;
    logic [31:0] r_wdata;
    logic [31:0] r_rdata;

    store_align u_align (
        .op_type  (op_type),
        .op_store (op_store),
        .off      (op_addr[1:0]),
        .rt       (op_wdata),
        .size     (a_size),
        .strobe   (a_strb),
        .wdata    (a_wdata)
    );

    assign wl_wr = (op_type == OP_WL) | (op_type == OP_WR);

`ifdef DATA_REQ_ADEL_CHECK_EN
    logic r_err;
    assign mis = is_misaligned(op_type, op_addr[1:0]);
    assign resp_err = (state == ST_RESP) & r_err;
`else
    assign mis = 1'b0;
    assign resp_err = 1'b0;
`endif

    assign op_ready = ((state == ST_IDLE) |
                       ((state == ST_RESP) & resp_ready)) & ~cancel;
    assign accept = op_valid & op_ready;

    always_comb begin
        nxt = state;
        unique case (state)
            ST_IDLE: begin
                if (accept)
                    nxt = mis ? ST_RESP : ST_REQ;
            end
            // a request once raised is never withdrawn
            ST_REQ: begin
                if (bus.data_addr_ok)
                    nxt = (cancel | cxl_q) ? ST_DROP : ST_WAIT;
            end
            ST_WAIT: begin
                if (cancel)
                    nxt = bus.data_data_ok ? ST_IDLE : ST_DROP;
                else if (bus.data_data_ok)
                    nxt = ST_RESP;
            end
            ST_DROP: begin
                if (bus.data_data_ok)
                    nxt = ST_IDLE;
            end
            ST_RESP: begin
                if (cancel)
                    nxt = ST_IDLE;
                else if (resp_ready)
                    nxt = accept ? (mis ? ST_RESP : ST_REQ)
                                 : ST_IDLE;
            end
            default: nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= ST_IDLE;
            cxl_q   <= 1'b0;
            r_store <= 1'b0;
            r_size  <= 2'd0;
            r_addr  <= 32'd0;
            r_strb  <= 4'd0;
            r_wdata <= 32'd0;
            r_rdata <= 32'd0;
`ifdef DATA_REQ_ADEL_CHECK_EN
            r_err   <= 1'b0;
`endif
        end else begin
            state <= nxt;
            cxl_q <= (state == ST_REQ) & ~bus.data_addr_ok &
                     (cxl_q | cancel);
            if (accept) begin
                r_store <= op_store;
                r_size  <= a_size;
                r_addr  <= wl_wr ? {op_addr[31:2], 2'b00} : op_addr;
                r_strb  <= a_strb;
                r_wdata <= a_wdata;
                r_rdata <= 32'd0;
`ifdef DATA_REQ_ADEL_CHECK_EN
                r_err   <= mis;
`endif
            end else if ((state == ST_WAIT) & bus.data_data_ok &
                         ~r_store) begin
                r_rdata <= bus.data_rdata;
            end
        end
    end

    assign bus.data_req   = (state == ST_REQ);
    assign bus.data_wr    = (state == ST_REQ) & r_store;
    assign bus.data_size  = r_size;
    assign bus.data_addr  = r_addr;
    assign bus.data_wstrb = r_strb;
    assign bus.data_wdata = r_wdata;

    assign resp_valid = (state == ST_RESP);
    assign resp_rdata = r_rdata;
    assign resp_store = (state == ST_RESP) & r_store;

endmodule

// File: tb/tb_data_sram_req.sv
// Bench for data_sram_req: directed cases plus random traffic
// against a transaction-level model.
module tb_data_sram_req;

    logic        clk;
    logic        reset;
    logic        cancel;
    logic        op_valid;
    logic        op_ready;
    logic        op_store;
    logic [2:0]  op_type;
    logic [31:0] op_addr;
    logic [31:0] op_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_store;
    logic        resp_err;

    data_sram_req_if bus();

    data_sram_req dut (
        .clk        (clk),
        .reset      (reset),
        .cancel     (cancel),
        .op_valid   (op_valid),
        .op_ready   (op_ready),
        .op_store   (op_store),
        .op_type    (op_type),
        .op_addr    (op_addr),
        .op_wdata   (op_wdata),
        .bus        (bus),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_store (resp_store),
        .resp_err   (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // stimulus for the coming cycle
    logic        s_valid, s_store, s_cancel, s_ready;
    logic        s_aok, s_dok, auto_slave;
    logic [2:0]  s_type;
    logic [31:0] s_addr, s_wdata, s_rdata;

    // model: the one op held by the issuer, if any
    logic        m_have, m_sent, m_done, m_kill, m_err, m_store;
    logic [2:0]  m_type;
    logic [31:0] m_addr, m_wdata, m_rdata;
    logic        sl_out;

    // snapshots for directed literal checks
    logic        n_req, n_wr, n_rv, n_rs, n_re;
    logic [1:0]  n_size;
    logic [3:0]  n_strb;
    logic [31:0] n_addr, n_wdata, n_rdata;

    task automatic chk(input string nm, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp,
                     $time);
        end
    endtask

    function automatic logic misal(input logic [2:0] t,
                                   input logic [31:0] a);
`ifdef DATA_REQ_ADEL_CHECK_EN
        if ((t == 3'd2 || t == 3'd3) && a[0]) return 1'b1;
        if ((t == 3'd4 || t == 3'd7) && a[1:0] != 2'd0) return 1'b1;
        return 1'b0;
`else
        return (t == 3'd7) && (a[1:0] == 2'd0) && 1'b0;
`endif
    endfunction

    // bus fields written from memory byte-lane semantics
    task automatic exp_bus(input logic st, input logic [2:0] ty,
                           input logic [31:0] a, input logic [31:0] rt,
                           output logic [1:0] sz,
                           output logic [31:0] ad,
                           output logic [3:0] sb,
                           output logic [31:0] wd);
        int o;
        logic [7:0] b [4];
        o = int'(a[1:0]);
        for (int i = 0; i < 4; i++) b[i] = rt[8*i +: 8];
        sb = 4'd0;
        wd = 32'd0;
        ad = a;
        sz = 2'd2;
        case (ty)
            3'd0, 3'd1: begin
                sz = 2'd0;
                for (int i = 0; i < 4; i++) wd[8*i +: 8] = b[0];
                sb[o] = 1'b1;
            end
            3'd2, 3'd3: begin
                sz = 2'd1;
                for (int i = 0; i < 4; i++) wd[8*i +: 8] = b[i % 2];
                sb[(o / 2) * 2] = 1'b1;
                sb[(o / 2) * 2 + 1] = 1'b1;
            end
            3'd5: begin
                ad = {a[31:2], 2'b00};
                for (int i = 0; i <= o; i++) begin
                    sb[i] = 1'b1;
                    wd[8*i +: 8] = b[i + 3 - o];
                end
            end
            3'd6: begin
                ad = {a[31:2], 2'b00};
                for (int i = o; i < 4; i++) begin
                    sb[i] = 1'b1;
                    wd[8*i +: 8] = b[i - o];
                end
            end
            default: begin
                sb = 4'hf;
                wd = rt;
            end
        endcase
        if (!st) sb = 4'd0;
    endtask

    task automatic step();
        logic e_req, e_rv, e_rdy, acc, mis;
        logic [1:0] x_sz;
        logic [31:0] x_ad, x_wd;
        logic [3:0] x_sb;
        @(negedge clk);
        if (auto_slave) begin
            s_aok = bus.data_req & ($urandom_range(0, 2) == 0);
            s_dok = sl_out ? ($urandom_range(0, 2) == 0)
                           : ($urandom_range(0, 39) == 0);
            s_rdata = $urandom;
        end
        op_valid = s_valid;
        op_store = s_store;
        op_type = s_type;
        op_addr = s_addr;
        op_wdata = s_wdata;
        cancel = s_cancel;
        resp_ready = s_ready;
        bus.data_addr_ok = s_aok;
        bus.data_data_ok = s_dok;
        bus.data_rdata = s_rdata;
        #1;
        e_req = m_have & ~m_sent & ~m_done;
        e_rv = m_have & m_done & ~m_kill;
        e_rdy = (~m_have | (e_rv & s_ready)) & ~s_cancel;
        chk("data_req", {31'd0, bus.data_req}, {31'd0, e_req});
        chk("op_ready", {31'd0, op_ready}, {31'd0, e_rdy});
        chk("resp_valid", {31'd0, resp_valid}, {31'd0, e_rv});
        if (e_req) begin
            exp_bus(m_store, m_type, m_addr, m_wdata,
                    x_sz, x_ad, x_sb, x_wd);
            chk("data_wr", {31'd0, bus.data_wr}, {31'd0, m_store});
            chk("data_size", {30'd0, bus.data_size}, {30'd0, x_sz});
            chk("data_addr", bus.data_addr, x_ad);
            chk("data_wstrb", {28'd0, bus.data_wstrb}, {28'd0, x_sb});
            if (m_store) chk("data_wdata", bus.data_wdata, x_wd);
        end
        if (e_rv) begin
            chk("resp_rdata", resp_rdata, m_rdata);
            chk("resp_store", {31'd0, resp_store}, {31'd0, m_store});
            chk("resp_err", {31'd0, resp_err}, {31'd0, m_err});
        end
        acc = s_valid & e_rdy;
        mis = misal(s_type, s_addr);
        if (m_have) begin
            if (e_rv) begin
                if (s_cancel | s_ready) m_have = 1'b0;
            end else if (!m_sent && !m_done) begin
                if (s_cancel) m_kill = 1'b1;
                if (s_aok) m_sent = 1'b1;
            end else if (m_sent && !m_done) begin
                if (s_cancel) m_kill = 1'b1;
                if (s_dok) begin
                    if (m_kill) m_have = 1'b0;
                    else begin
                        m_done = 1'b1;
                        m_rdata = m_store ? 32'd0 : s_rdata;
                    end
                end
            end
        end
        if (acc) begin
            m_have = 1'b1;
            m_sent = 1'b0;
            m_kill = 1'b0;
            m_done = mis;
            m_err = mis;
            m_rdata = 32'd0;
            m_store = s_store;
            m_type = s_type;
            m_addr = s_addr;
            m_wdata = s_wdata;
        end
        sl_out = (sl_out & ~s_dok) | (e_req & s_aok);
    endtask

    task automatic idle_in();
        s_valid = 1'b0;
        s_cancel = 1'b0;
        s_ready = 1'b1;
        s_aok = 1'b0;
        s_dok = 1'b0;
    endtask

    task automatic run_op(input logic st, input logic [2:0] ty,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int hold, input logic [31:0] rd);
        idle_in();
        s_valid = 1'b1;
        s_store = st;
        s_type = ty;
        s_addr = a;
        s_wdata = wd;
        step();
        s_valid = 1'b0;
        step();
        n_req = bus.data_req;
        n_wr = bus.data_wr;
        n_size = bus.data_size;
        n_addr = bus.data_addr;
        n_strb = bus.data_wstrb;
        n_wdata = bus.data_wdata;
        repeat (hold) step();
        s_aok = 1'b1;
        step();
        s_aok = 1'b0;
        s_dok = 1'b1;
        s_rdata = rd;
        step();
        s_dok = 1'b0;
        step();
        n_rv = resp_valid;
        n_rdata = resp_rdata;
        n_rs = resp_store;
        n_re = resp_err;
    endtask

    initial begin
        auto_slave = 1'b0;
        idle_in();
        s_store = 1'b0;
        s_type = 3'd0;
        s_addr = 32'd0;
        s_wdata = 32'd0;
        s_rdata = 32'd0;
        {m_have, m_sent, m_done, m_kill, m_err, m_store} = 6'd0;
        m_type = 3'd0;
        m_addr = 32'd0;
        m_wdata = 32'd0;
        m_rdata = 32'd0;
        sl_out = 1'b0;
        reset = 1'b1;
        cancel = 1'b0;
        op_valid = 1'b0;
        op_store = 1'b0;
        op_type = 3'd0;
        op_addr = 32'd0;
        op_wdata = 32'd0;
        resp_ready = 1'b0;
        bus.data_addr_ok = 1'b0;
        bus.data_data_ok = 1'b0;
        bus.data_rdata = 32'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_req", {31'd0, bus.data_req}, 32'd0);
        chk("rst_wr", {31'd0, bus.data_wr}, 32'd0);
        chk("rst_size", {30'd0, bus.data_size}, 32'd0);
        chk("rst_addr", bus.data_addr, 32'd0);
        chk("rst_strb", {28'd0, bus.data_wstrb}, 32'd0);
        chk("rst_wdata", bus.data_wdata, 32'd0);
        chk("rst_rv", {31'd0, resp_valid}, 32'd0);
        chk("rst_rs", {31'd0, resp_store}, 32'd0);
        chk("rst_re", {31'd0, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        reset = 1'b0;

        run_op(1'b1, 3'd0, 32'h1003, 32'h000000a5, 0, 32'h12345678);
        chk("sb_req", {31'd0, n_req}, 32'd1);
        chk("sb_wr", {31'd0, n_wr}, 32'd1);
        chk("sb_size", {30'd0, n_size}, 32'd0);
        chk("sb_strb", {28'd0, n_strb}, 32'h8);
        chk("sb_wdata", n_wdata, 32'ha5a5a5a5);
        chk("sb_rv", {31'd0, n_rv}, 32'd1);
        chk("sb_rs", {31'd0, n_rs}, 32'd1);
        chk("sb_rdata", n_rdata, 32'd0);

        run_op(1'b1, 3'd5, 32'h2001, 32'h11223344, 1, 32'h0);
        chk("swl_addr", n_addr, 32'h2000);
        chk("swl_size", {30'd0, n_size}, 32'd2);
        chk("swl_strb", {28'd0, n_strb}, 32'h3);
        chk("swl_wdata", n_wdata, 32'h00001122);

        run_op(1'b1, 3'd6, 32'h2002, 32'h11223344, 0, 32'h0);
        chk("swr_addr", n_addr, 32'h2000);
        chk("swr_size", {30'd0, n_size}, 32'd2);
        chk("swr_strb", {28'd0, n_strb}, 32'hc);
        chk("swr_wdata", n_wdata, 32'h33440000);

        run_op(1'b0, 3'd4, 32'h3000, 32'h0, 3, 32'hdeadbeef);
        chk("lw_addr", n_addr, 32'h3000);
        chk("lw_wr", {31'd0, n_wr}, 32'd0);
        chk("lw_strb", {28'd0, n_strb}, 32'd0);
        chk("lw_rv", {31'd0, n_rv}, 32'd1);
        chk("lw_rdata", n_rdata, 32'hdeadbeef);
        chk("lw_rs", {31'd0, n_rs}, 32'd0);

        // cancel while the request is still on the bus
        idle_in();
        s_valid = 1'b1;
        s_store = 1'b0;
        s_type = 3'd4;
        s_addr = 32'h5000;
        step();
        s_valid = 1'b0;
        s_cancel = 1'b1;
        step();
        s_cancel = 1'b0;
        step();
        chk("cx_req_held", {31'd0, bus.data_req}, 32'd1);
        s_aok = 1'b1;
        step();
        s_aok = 1'b0;
        s_dok = 1'b1;
        s_rdata = 32'h55aa55aa;
        step();
        s_dok = 1'b0;
        step();
        chk("cx_no_resp", {31'd0, resp_valid}, 32'd0);
        chk("cx_idle", {31'd0, op_ready}, 32'd1);

`ifdef DATA_REQ_ADEL_CHECK_EN
        idle_in();
        s_valid = 1'b1;
        s_store = 1'b0;
        s_type = 3'd2;
        s_addr = 32'h4001;
        step();
        s_valid = 1'b0;
        step();
        chk("adel_rv", {31'd0, resp_valid}, 32'd1);
        chk("adel_err", {31'd0, resp_err}, 32'd1);
        chk("adel_req", {31'd0, bus.data_req}, 32'd0);
        step();
        chk("adel_req2", {31'd0, bus.data_req}, 32'd0);
`else
        run_op(1'b0, 3'd2, 32'h4001, 32'h0, 0, 32'hcafe0001);
        chk("lh_req", {31'd0, n_req}, 32'd1);
        chk("lh_addr", n_addr, 32'h4001);
        chk("lh_size", {30'd0, n_size}, 32'd1);
        chk("lh_err", {31'd0, n_re}, 32'd0);
        chk("lh_rdata", n_rdata, 32'hcafe0001);
`endif

        auto_slave = 1'b1;
        for (int c = 0; c < 4000; c++) begin
            s_valid = ($urandom_range(0, 2) != 0);
            s_store = $urandom_range(0, 1) == 1;
            s_type = 3'($urandom_range(0, 7));
            s_addr = $urandom;
            s_wdata = $urandom;
            s_cancel = ($urandom_range(0, 15) == 0);
            s_ready = ($urandom_range(0, 3) != 0);
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/data_sram_req.md
# data_sram_req

Data-side request issuer between the EXE and MEM pipeline stages. It accepts one memory operation at a time, performs store byte-lane alignment, and drives the SRAM-like data bus (req/addr_ok/data_ok). It returns the raw read word, or a store completion, to the MEM stage over a valid/ready handshake. It is the outbound counterpart of the MEM-stage load-alignment logic, which still does the load byte selection on `resp_rdata`.

## Interface
Parameters: none.

Ports:
- `clk`  in  1  clock
- `reset`  in  1  synchronous, active-high reset
- `cancel`  in  1  pipeline flush (exception/eret); discards the in-flight op
- `op_valid`  in  1  EXE presents an op
- `op_ready`  out  1  op accepted this cycle when `op_valid & op_ready`
- `op_store`  in  1  1 = store, 0 = load
- `op_type`  in  3  0 b, 1 bu, 2 h, 3 hu, 4 w, 5 wl, 6 wr (7 is illegal and treated as w)
- `op_addr`  in  32  effective byte address
- `op_wdata`  in  32  rt value
- `data_req`  out  1  bus request
- `data_wr`  out  1  write
- `data_size`  out  2  0 byte, 1 half, 2 word
- `data_addr`  out  32  bus address
- `data_wstrb`  out  4  byte write strobes
- `data_wdata`  out  32  lane-aligned write data
- `data_addr_ok`  in  1  request accepted
- `data_data_ok`  in  1  data phase done
- `data_rdata`  in  32  read data
- `resp_valid`  out  1  response to MEM
- `resp_ready`  in  1  MEM takes response
- `resp_rdata`  out  32  raw read word (0 for stores)
- `resp_store`  out  1  response belongs to a store
- `resp_err`  out  1  misaligned h/w op; no bus access was made

## Operation
- FSM states:
  - IDLE
  - REQ: `data_req` held
  - WAIT: awaiting `data_ok`
  - RESP: `resp_valid` held
  - DROP: cancelled; absorbs `data_ok`
- `op_ready = (IDLE | (RESP & resp_ready)) & ~cancel`.
- On accept, the op is registered and the FSM goes to REQ. An op flagged as misaligned goes straight to RESP with `resp_err` = 1.
- Misaligned means: h/hu with `addr[0]` = 1, or w with `addr[1:0]` ≠ 0.
- In REQ, `data_req` = 1 and all `data_*` outputs are stable until `addr_ok`. `addr_ok` moves the FSM to WAIT.
- In WAIT, `data_ok` captures `data_rdata` into `resp_rdata` and moves the FSM to RESP.
- In RESP, `resp_ready` moves the FSM to IDLE, or back to REQ if a new op is accepted in the same cycle.
- Size, address and strobe, with `o = addr[1:0]`:
  - b/bu: size 0, strobe `1<<o`, `wdata = {4{rt[7:0]}}`.
  - h/hu: size 1, strobe `o[1]` ? 1100 : 0011, `wdata = {2{rt[15:0]}}`.
  - w: size 2, strobe 1111, `wdata = rt`.
  - wl/wr: size 2, `data_addr = {addr[31:2], 2'b00}`.
  - Other ops: `data_addr = op_addr`.
  - swl, by offset o = 0/1/2/3:
    - strobe 0001 / 0011 / 0111 / 1111
    - wdata `rt>>24` / `rt>>16` / `rt>>8` / `rt`
  - swr, by offset o = 0/1/2/3:
    - strobe 1111 / 1110 / 1100 / 1000
    - wdata `rt` / `rt<<8` / `rt<<16` / `rt<<24`
  - Loads: strobe 0000 and `data_wr` = 0.
- `cancel` behaviour by state:
  - IDLE: no effect.
  - REQ: the request is never withdrawn. `data_req` stays high until `addr_ok`, then the FSM goes to DROP.
  - WAIT: go to DROP.
  - DROP: the next `data_ok` returns the FSM to IDLE and produces no response.
  - RESP: `resp_valid` clears and the FSM goes to IDLE.
- `cancel` together with `addr_ok` in REQ goes to DROP.
- `cancel` together with `data_ok` in WAIT goes to IDLE; the data is discarded.

## Timing
- Reset: FSM = IDLE. `data_req`, `data_wr`, `resp_valid`, `resp_store` and `resp_err` = 0. `data_size`, `data_addr`, `data_wstrb`, `data_wdata` and `resp_rdata` = 0.
- All outputs are registered or decoded from the FSM state; there is no combinational path from bus inputs to bus outputs.
- Accept at cycle T gives `data_req` = 1 at T+1.
- `addr_ok` at cycle A gives WAIT at A+1.
- `data_ok` at cycle D gives `resp_valid` at D+1.
- Minimum load latency is 3 cycles from accept to `resp_valid`.
- A misaligned op gives `resp_valid` at T+1.
- `data_ok` while in REQ or IDLE is a protocol violation and is ignored.
- At most one transaction is outstanding at any time.

## Configuration
- `DATA_REQ_ADEL_CHECK_EN`
  - Defined: misaligned h/w ops are detected, never issued on the bus, and answered with `resp_err` = 1.
  - Undefined: no alignment check. `resp_err` is tied to 0, and misaligned ops are issued with `addr` unchanged.

## Structure
- Package `mem_op_pkg`: `op_type` encodings, FSM state encoding, and size constants.
- Sub-module `store_align` (combinational): takes `op_type`, `op_store`, `addr[1:0]` and `rt`, and produces size, strobe and wdata. It is instantiated once, on the accept-cycle inputs.

## Test plan
- sb with addr 0x1003, rt 0x000000A5: bus shows size 0, strobe 1000, wdata 0xA5A5A5A5, `wr` = 1. After `addr_ok` then `data_ok`, the response has `resp_store` = 1.
- swl with addr 0x2001, rt 0x11223344: addr 0x2000, size 2, strobe 0011, wdata 0x00001122.
- swr with addr 0x2002, rt 0x11223344: addr 0x2000, size 2, strobe 1100, wdata 0x33440000.
- lw from 0x3000 with `addr_ok` held low for 3 cycles: `req` and all outputs are stable throughout. `data_ok` with rdata 0xDEADBEEF gives `resp_rdata` = 0xDEADBEEF one cycle later.
- `cancel` in REQ: `req` stays high until `addr_ok`. The following `data_ok` produces no `resp_valid`, and the FSM returns to IDLE.
- lh at 0x4001 with the macro defined: `resp_valid` and `resp_err` = 1 at T+1, and `data_req` never rises.
